decap_r_recover: RTL and testbench
==================================

Name: decap_r_recover

Overview:
- Decapsulation-side producer of the short polynomial r that the encapsulation block consumes when rfd=1 (re-encapsulation check).
- Reads the mod-3 product polynomial e (coefficients 0..p-1) from an upstream memory and reduces each coefficient to {-1,0,1}.
- Counts the weight and writes r into the r memory: the reduced polynomial if weight==t, otherwise the default r (1 at indices 0..t-1, 0 elsewhere).
- Drives degr and rfd toward encapsulation.

Parameters:
- CW, 13, coefficient width (memory data width).
- AW, 11, memory address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins recovery; ignored unless in IDLE
- p  in  12  polynomial length (677 in product; 2..2047 legal)
- t  in  12  required weight
- mem_address_oe  out  AW  read address into e memory
- mem_outpute  in  CW  e coefficient, two's complement, valid 1 cycle after address (synchronous read)
- mem_address_ir  out  AW  write address into r memory
- mem_inputr  out  CW  r coefficient: 0, 1, or 13'h1FFF (-1)
- write_enabler  out  1  r memory write strobe
- degr  out  AW  highest index written with a nonzero coefficient (0 if none)
- weight  out  12  count of nonzero reduced coefficients from pass 1
- weight_ok  out  1  weight==t, valid from pass 2 onward
- rfd  out  1  r ready for decap; high from done until next accepted start or rst
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all address outputs 0, mem_inputr 0, write_enabler 0, degr 0, weight 0, weight_ok 0, rfd 0, done 0; FSM in IDLE. rst mid-operation aborts within the same edge; no further writes occur; r memory contents are undefined.
- Reduction: the signed coefficient x maps to m = x mod 3 in {0,1,2} (true modulo, also for negative x). Output is 0, 1, or -1 (13'h1FFF for m=2). Purely combinational on mem_outpute.
- States:
  - IDLE: waits for start. On start: rfd<=0, weight<=0, address counter k<=0, go to RD1.
  - RD1: issue mem_address_oe=k for k=0..p-1, one per cycle. Each cycle after the first, accumulate weight from the returning data (1-cycle lag). After issuing p-1, go to FL1.
  - FL1: accumulate the last coefficient, go to CHK.
  - CHK: weight_ok<=(weight==t); k<=0; degr<=0; go to RD2.
  - RD2: issue mem_address_oe=k for k=0..p-1. One cycle later, write_enabler=1 with mem_address_ir=the lagged k.
    - mem_inputr = reduced value if weight_ok, else (lagged k < t ? 1 : 0).
    - Whenever the written value is nonzero, degr<=lagged k.
    - After issuing p-1, go to FL2.
  - FL2: final write (index p-1), go to DONE.
  - DONE: done=1 for one cycle, rfd<=1, back to IDLE.
- Latency: the start cycle is cycle 0.
  - RD1 occupies cycles 1..p; FL1 p+1; CHK p+2.
  - RD2 p+3..2p+2, writes on cycles p+4..2p+3.
  - done high on cycle 2p+4.
- Exactly p writes per run, addresses strictly ascending 0..p-1, no gaps or duplicates. write_enabler is low in every other state.
- Width rules: weight saturates at 4095 (unreachable for legal p). Comparisons with t and p are 12-bit unsigned.
- Boundaries:
  - t=0: weight_ok only if e reduces to all-zero; the default r is all zero with degr=0.
  - t>p: weight_ok is necessarily 0; default r writes 1 at every index and degr=p-1.
  - start while busy or in DONE: ignored.
  - start held high across IDLE re-entry: a new run begins and rfd drops on the accepted start.

Test Plan:
- p=7, t=2, e={0,4,0,0,-1,0,3} -> reduced {0,1,0,0,-1,0,0}; weight=2, weight_ok=1; writes addr0..6 = {0,1,0,0,1FFF,0,0}; degr=4; done on cycle 18; rfd=1 afterwards.
- p=7, t=3, same e -> weight=2, weight_ok=0; writes {1,1,1,0,0,0,0}; degr=2.
- p=677, t=250, e with exactly 250 nonzero residues including negative inputs (-2->1, -4->-1, 13'h1000) -> weight_ok=1; 677 writes; done on cycle 1358; write data matches the software model.
- rst asserted on cycle 10 of a p=677 run, then start 3 cycles later -> outputs return to reset values immediately after rst; the second run completes normally with correct weight.
- start pulsed during RD1 and RD2 -> ignored; exactly p writes and one done pulse.
- t=0 with all-zero e -> weight_ok=1, all writes 0, degr=0; t=9 with p=7 -> all-ones r, degr=6.

Source files
------------

// File: rtl/decap_r_recover.sv
// Recovers the short polynomial r from the mod-3 product e: the first pass counts the weight,
// the second pass writes either the reduced e or the default r into the r memory.
module decap_r_recover #(
   parameter int CW = 13,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [11:0]   p,
   input  logic [11:0]   t,
   output logic [AW-1:0] mem_address_oe,
   input  logic [CW-1:0] mem_outpute,
   output logic [AW-1:0] mem_address_ir,
   output logic [CW-1:0] mem_inputr,
   output logic          write_enabler,
   output logic [AW-1:0] degr,
   output logic [11:0]   weight,
   output logic          weight_ok,
   output logic          rfd,
   output logic          done
);

   // state | meaning
   // IDLE  | waiting for start
   // RD1   | pass 1: issue reads 0..p-1, count weight of lagged data
   // FL1   | count the last coefficient of pass 1
   // CHK   | latch weight_ok, rewind address counter
   // RD2   | pass 2: issue reads 0..p-1, write lagged index
   // FL2   | write the last index p-1
   // DONE  | completion pulse, raise rfd
   typedef enum logic [2:0] {IDLE, RD1, FL1, CHK, RD2, FL2, DONE} state_t;

   localparam logic signed [CW-1:0] ONE   = CW'(1);
   localparam logic signed [CW-1:0] TWO   = CW'(2);
   localparam logic signed [CW-1:0] THREE = CW'(3);

   state_t state, state_nx;
   logic [AW-1:0] k, k_lag;
   logic rd_vld;
   logic signed [CW-1:0] xs, rem, m;
   logic [CW-1:0] red, wdata;
   logic red_nz, last, wr;

   // % truncates toward zero, so a negative remainder is folded back into 0..2
   always_comb begin
      xs  = $signed(mem_outpute);
      rem = xs % THREE;
      m   = rem[CW-1] ? rem + THREE : rem;
      red = '0;
      if (m == ONE)
         red = CW'(1);
      else if (m == TWO)
         red = '1;
      red_nz = (red != '0);
   end

   always_comb begin
      last     = (12'(k) == p - 12'd1);
      wr       = ((state == RD2) && rd_vld) || (state == FL2);
      wdata    = weight_ok ? red : ((12'(k_lag) < t) ? CW'(1) : '0);
      done     = (state == DONE);
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RD1;
         RD1:     if (last) state_nx = FL1;
         FL1:     state_nx = CHK;
         CHK:     state_nx = RD2;
         RD2:     if (last) state_nx = FL2;
         FL2:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign mem_address_oe = k;
   assign mem_address_ir = k_lag;
   assign write_enabler  = wr;
   assign mem_inputr     = wr ? wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         k_lag     <= '0;
         rd_vld    <= 1'b0;
         weight    <= '0;
         weight_ok <= 1'b0;
         degr      <= '0;
         rfd       <= 1'b0;
      end else begin
         state  <= state_nx;
         k_lag  <= k;
         rd_vld <= (state == RD1) || (state == RD2);
         case (state)
            IDLE: begin
               if (start) begin
                  rfd    <= 1'b0;
                  weight <= '0;
                  k      <= '0;
               end
            end
            RD1: begin
               if (rd_vld && red_nz && weight != 12'hFFF)
                  weight <= weight + 12'd1;
               if (!last)
                  k <= k + AW'(1);
            end
            FL1: begin
               if (red_nz && weight != 12'hFFF)
                  weight <= weight + 12'd1;
            end
            CHK: begin
               weight_ok <= (weight == t);
               k         <= '0;
               degr      <= '0;
            end
            RD2: begin
               if (!last)
                  k <= k + AW'(1);
            end
            DONE:    rfd <= 1'b1;
            default: ;
         endcase
         if (wr && wdata != '0)
            degr <= k_lag;
      end
   end

endmodule

// File: tb/tb_decap_r_recover.sv
// Scoreboard bench for decap_r_recover: stimulus pushes expected writes and results,
// a negedge monitor pops and compares whenever the DUT writes or signals done.
module tb_decap_r_recover;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [11:0] p, t;
   logic [10:0] mem_address_oe, mem_address_ir, degr;
   logic [12:0] mem_outpute, mem_inputr;
   logic        write_enabler, weight_ok, rfd, done;
   logic [11:0] weight;

   decap_r_recover #(.CW(13), .AW(11)) dut (
      .clk(clk), .rst(rst), .start(start), .p(p), .t(t),
      .mem_address_oe(mem_address_oe), .mem_outpute(mem_outpute),
      .mem_address_ir(mem_address_ir), .mem_inputr(mem_inputr),
      .write_enabler(write_enabler), .degr(degr), .weight(weight),
      .weight_ok(weight_ok), .rfd(rfd), .done(done)
   );

   always #5 clk = ~clk;

   logic [12:0] e_mem [0:2047];
   always @(posedge clk) mem_outpute <= e_mem[mem_address_oe];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int a; logic [12:0] d;} wr_t;
   typedef struct {int w; int ok; int dg; int cycles;} res_t;
   wr_t  exp_wr[$];
   res_t exp_res[$];

   int vectors = 0, miscompares = 0;
   int start_cyc = 0, done_cnt = 0, wr_cnt = 0;
   logic rfd_chk = 1'b0;
   logic [12:0] ev [0:6];
   logic [12:0] rv [0:6];

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [12:0] mod3(input logic [12:0] x);
      int v, r;
      v = int'($signed(x));
      r = ((v % 3) + 3) % 3;
      if (r == 0) return 13'h0000;
      if (r == 1) return 13'h0001;
      return 13'h1FFF;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (rfd_chk) begin
            check("rfd_after_done", int'(rfd), 1);
            rfd_chk = 1'b0;
         end
         if (write_enabler) begin
            wr_t w;
            wr_cnt++;
            if (exp_wr.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_write: addr %0d data %0h, none expected", mem_address_ir, mem_inputr);
            end else begin
               w = exp_wr.pop_front();
               check("wr_addr", int'(mem_address_ir), w.a);
               check("wr_data", int'(mem_inputr), int'(w.d));
            end
         end
         if (done) begin
            res_t r;
            done_cnt++;
            if (exp_res.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_done: done pulse with no run expected");
            end else begin
               r = exp_res.pop_front();
               check("weight", int'(weight), r.w);
               check("weight_ok", int'(weight_ok), r.ok);
               check("degr", int'(degr), r.dg);
               check("done_cycle", cyc - start_cyc, r.cycles);
               check("writes_outstanding", exp_wr.size(), 0);
               rfd_chk = 1'b1;
            end
         end
      end
   end

   task automatic load_e7();
      for (int i = 0; i < 7; i++) e_mem[i] = ev[i];
   endtask

   task automatic push7(input int w, input int ok, input int dg);
      wr_t x;
      res_t r;
      for (int i = 0; i < 7; i++) begin
         x.a = i; x.d = rv[i];
         exp_wr.push_back(x);
      end
      r.w = w; r.ok = ok; r.dg = dg; r.cycles = 18;
      exp_res.push_back(r);
   endtask

   task automatic run_start();
      @(negedge clk);
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n0;
      bit seen;
      n0 = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk); #1;
         if (done_cnt > n0) seen = 1'b1;
      end
      if (!seen) begin
         vectors++; miscompares++;
         $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
      @(negedge clk); #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_addr_oe"}, int'(mem_address_oe), 0);
      check({tag, "_addr_ir"}, int'(mem_address_ir), 0);
      check({tag, "_inputr"}, int'(mem_inputr), 0);
      check({tag, "_we"}, int'(write_enabler), 0);
      check({tag, "_degr"}, int'(degr), 0);
      check({tag, "_weight"}, int'(weight), 0);
      check({tag, "_weight_ok"}, int'(weight_ok), 0);
      check({tag, "_rfd"}, int'(rfd), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   task automatic load_big();
      logic [12:0] nzv [0:6];
      logic [12:0] zv [0:4];
      int cnt;
      nzv = '{13'h1FFE, 13'h1FFC, 13'h1000, 13'h0004, 13'h0005, 13'h1FFF, 13'h0001};
      zv  = '{13'h0000, 13'h0003, 13'h1FFD, 13'h0FFF, 13'h1FFA};
      cnt = 0;
      for (int i = 0; i < 677; i++) begin
         if ((i % 8) < 3 && cnt < 250) begin
            e_mem[i] = nzv[cnt % 7];
            cnt++;
         end else begin
            e_mem[i] = zv[i % 5];
         end
      end
   endtask

   task automatic push_big(input int tt);
      wr_t x;
      res_t r;
      int last_nz;
      last_nz = 0;
      for (int i = 0; i < 677; i++) begin
         x.a = i; x.d = mod3(e_mem[i]);
         if (x.d != 13'h0) last_nz = i;
         exp_wr.push_back(x);
      end
      r.w = 250; r.ok = (tt == 250) ? 1 : 0; r.dg = last_nz; r.cycles = 1358;
      exp_res.push_back(r);
   endtask

   initial begin
      int wc0, dc0;
      rst = 1'b1; start = 1'b0; p = 12'd7; t = 12'd2;
      for (int i = 0; i < 2048; i++) e_mem[i] = 13'h0;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst = 1'b0;

      // p=7, t=2: reduced e has weight 2
      ev = '{13'h0000, 13'h0004, 13'h0000, 13'h0000, 13'h1FFF, 13'h0000, 13'h0003};
      load_e7();
      rv = '{13'h0000, 13'h0001, 13'h0000, 13'h0000, 13'h1FFF, 13'h0000, 13'h0000};
      push7(2, 1, 4);
      run_start();
      wait_done(100);

      // t=3: weight mismatch, default r
      t = 12'd3;
      rv = '{13'h1, 13'h1, 13'h1, 13'h0, 13'h0, 13'h0, 13'h0};
      push7(2, 0, 2);
      run_start();
      wait_done(100);

      // t=9 > p: all ones
      t = 12'd9;
      rv = '{13'h1, 13'h1, 13'h1, 13'h1, 13'h1, 13'h1, 13'h1};
      push7(2, 0, 6);
      run_start();
      wait_done(100);

      // t=0 with all-zero e (multiples of 3 included)
      t = 12'd0;
      ev = '{13'h0000, 13'h0003, 13'h1FFD, 13'h0000, 13'h0006, 13'h0000, 13'h1FFA};
      load_e7();
      rv = '{13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0};
      push7(0, 1, 0);
      run_start();
      wait_done(100);

      // start pulses during RD1 and RD2 must be ignored
      t = 12'd2;
      ev = '{13'h0000, 13'h0004, 13'h0000, 13'h0000, 13'h1FFF, 13'h0000, 13'h0003};
      load_e7();
      rv = '{13'h0000, 13'h0001, 13'h0000, 13'h0000, 13'h1FFF, 13'h0000, 13'h0000};
      wc0 = wr_cnt; dc0 = done_cnt;
      push7(2, 1, 4);
      run_start();
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(100);
      repeat (5) @(negedge clk);
      #1;
      check("ignored_start_writes", wr_cnt - wc0, 7);
      check("ignored_start_dones", done_cnt - dc0, 1);

      // p=677, t=250 with negative inputs
      p = 12'd677; t = 12'd250;
      load_big();
      push_big(250);
      run_start();
      wait_done(2000);

      // reset on cycle 10 of a run, restart 3 cycles later
      run_start();
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_reset("midrun");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      wc0 = wr_cnt;
      push_big(250);
      run_start();
      wait_done(2000);
      check("rerun_writes", wr_cnt - wc0, 677);

      check("scoreboard_writes_left", exp_wr.size(), 0);
      check("scoreboard_results_left", exp_res.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
